// File: rtl/spi_master_ingress.sv
// 2-bit-per-strobe SPI MISO deserialiser: drops IDLE filler bytes and writes data bytes to the readout FIFO.
// Optional statistics counters are enabled with `define SPI_INGRESS_STATS_EN.
module spi_master_ingress #(
  parameter logic [7:0]  IDLE_VALUE   = 8'h3D,
  parameter int unsigned SKIP_SAMPLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_csn,
  input  logic       sample_en,
  input  logic [1:0] spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_write,
  input  logic       rx_full,
  output logic       overflow,
  input  logic       overflow_clear,
  output logic       partial_byte,
  output logic       frame_active
`ifdef SPI_INGRESS_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [15:0] data_count,
  output logic [15:0] idle_count,
  output logic [15:0] lost_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT} state_t;

  localparam state_t     START_STATE = (SKIP_SAMPLES == 0) ? S_SHIFT : S_SKIP;
  localparam logic [1:0] SKIP_LAST   = 2'(SKIP_SAMPLES - 1);

  state_t     state, state_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [1:0] pair_cnt, pair_nxt;
  logic [1:0] skip_cnt, skip_nxt;
  logic [7:0] byte_val;
  logic       byte_done, part_nxt;
  logic       wr_nxt, lost_nxt, idle_drop;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    pair_nxt  = pair_cnt;
    skip_nxt  = skip_cnt;
    byte_done = 1'b0;
    part_nxt  = 1'b0;
    byte_val  = {spi_miso, shift_q[7:2]};
    if (spi_csn) begin
      // CSN high overrides any strobe in the same cycle and discards pending pairs
      state_nxt = S_IDLE;
      shift_nxt = '0;
      pair_nxt  = '0;
      skip_nxt  = '0;
      part_nxt  = (state == S_SHIFT) && (pair_cnt != 2'd0);
    end else begin
      case (state)
        S_IDLE: state_nxt = START_STATE;
        S_SKIP: begin
          if (sample_en) begin
            if (skip_cnt == SKIP_LAST) begin
              skip_nxt  = '0;
              state_nxt = S_SHIFT;
            end else begin
              skip_nxt = skip_cnt + 2'd1;
            end
          end
        end
        S_SHIFT: begin
          if (sample_en) begin
            shift_nxt = byte_val;
            pair_nxt  = pair_cnt + 2'd1;
            byte_done = (pair_cnt == 2'd3);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign idle_drop = byte_done && (byte_val == IDLE_VALUE);
  assign wr_nxt    = byte_done && (byte_val != IDLE_VALUE) && !rx_full;
  assign lost_nxt  = byte_done && (byte_val != IDLE_VALUE) && rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      shift_q      <= '0;
      pair_cnt     <= '0;
      skip_cnt     <= '0;
      rx_data      <= '0;
      rx_write     <= 1'b0;
      overflow     <= 1'b0;
      partial_byte <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_q      <= shift_nxt;
      pair_cnt     <= pair_nxt;
      skip_cnt     <= skip_nxt;
      rx_write     <= wr_nxt;
      partial_byte <= part_nxt;
      frame_active <= (state != S_IDLE);
      if (wr_nxt) rx_data <= byte_val;
      if (lost_nxt) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

`ifdef SPI_INGRESS_STATS_EN
  // Saturating counters; a clear in the same cycle discards any increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_count <= '0;
      idle_count <= '0;
      lost_count <= '0;
    end else if (stats_clear) begin
      data_count <= '0;
      idle_count <= '0;
      lost_count <= '0;
    end else begin
      if (wr_nxt && data_count != 16'hFFFF) data_count <= data_count + 16'd1;
      if (idle_drop && idle_count != 16'hFFFF) idle_count <= idle_count + 16'd1;
      if (lost_nxt && lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_ingress.sv
// Directed plus randomized bench for spi_master_ingress; expected bytes come from a frame-level byte model.
module tb_spi_master_ingress;

  localparam logic [7:0]  IDLE_V = 8'h3D;
  localparam int unsigned SKIP   = 1;

  logic       clk = 1'b0;
  logic       rst, spi_csn, sample_en, rx_full, overflow_clear;
  logic [1:0] spi_miso;
  logic [7:0] rx_data;
  logic       rx_write, overflow, partial_byte, frame_active;
`ifdef SPI_INGRESS_STATS_EN
  logic        stats_clear;
  logic [15:0] data_count, idle_count, lost_count;
`endif

  spi_master_ingress #(.IDLE_VALUE(IDLE_V), .SKIP_SAMPLES(SKIP)) dut (
    .clk(clk), .rst(rst), .spi_csn(spi_csn), .sample_en(sample_en), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_write(rx_write), .rx_full(rx_full), .overflow(overflow),
    .overflow_clear(overflow_clear), .partial_byte(partial_byte), .frame_active(frame_active)
`ifdef SPI_INGRESS_STATS_EN
    , .stats_clear(stats_clear), .data_count(data_count), .idle_count(idle_count),
    .lost_count(lost_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  wq[$];
  int unsigned wcyc[$];
  int unsigned npart = 0;
  always @(negedge clk) begin
    if (rx_write) begin
      wq.push_back(rx_data);
      wcyc.push_back(cyc);
    end
    if (partial_byte) npart++;
  end

  int unsigned passed = 0, total = 0;
  int unsigned s_cyc;
  int unsigned exp_data = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] p, input int unsigned gap);
    sample_en = 1'b1;
    spi_miso  = p;
    s_cyc     = cyc;
    tick();
    sample_en = 1'b0;
    spi_miso  = 2'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    for (int k = 0; k < 4; k++) strobe(b[2*k +: 2], gap);
  endtask

  task automatic start_frame();
    spi_csn = 1'b0;
    tick();
    repeat (SKIP) strobe(2'($urandom), 0);
  endtask

  task automatic end_frame();
    spi_csn = 1'b1;
    tick();
    tick();
  endtask

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
  endtask

  // Every expected byte must appear in order, and nothing else
  task automatic cmp_queue(input string tag);
    chk({tag, "_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_data"}, (i < wq.size()) ? {24'h0, wq[i]} : 32'hDEAD, {24'h0, exp_q[i]});
  endtask

  initial begin
    rst = 1'b1; spi_csn = 1'b1; sample_en = 1'b0; spi_miso = 2'b00;
    rx_full = 1'b0; overflow_clear = 1'b0;
`ifdef SPI_INGRESS_STATS_EN
    stats_clear = 1'b0;
`endif
    tick(); tick();
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_write", rx_write, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_partial", partial_byte, 1'b0);
    chk("rst_frame_active", frame_active, 1'b0);
    rst = 1'b0;
    tick();

    // basic byte with wait slot and one clk write latency
    clear_mon();
    start_frame();
    send_byte(8'hA5, 1);
    tick(); tick();
    chk("a5_count", wq.size(), 1);
    chk("a5_data", (wq.size() > 0) ? {24'h0, wq[0]} : 32'hDEAD, 32'hA5);
    chk("a5_latency", (wcyc.size() > 0) ? wcyc[0] - s_cyc : 32'hDEAD, 1);
    chk("active_in_frame", frame_active, 1'b1);
    end_frame();
    chk("active_after_frame", frame_active, 1'b0);

    // idle filler bytes are dropped
    clear_mon();
    start_frame();
    repeat (3) send_byte(IDLE_V, 0);
    tick(); tick();
    chk("idle_no_write", wq.size(), 0);
`ifdef SPI_INGRESS_STATS_EN
    chk("idle_count", idle_count, 3);
`endif
    end_frame();

    // overflow: set on lost byte, set beats clear, lone clear works
    clear_mon();
    rx_full = 1'b1;
    start_frame();
    send_byte(8'h11, 0);
    tick();
    chk("ovf_no_write", wq.size(), 0);
    chk("ovf_set", overflow, 1'b1);
    for (int k = 0; k < 3; k++) strobe(8'h22 >> (2*k), 1);
    sample_en = 1'b1; spi_miso = 2'b00; overflow_clear = 1'b1;
    tick();
    sample_en = 1'b0; overflow_clear = 1'b0;
    chk("ovf_set_beats_clear", overflow, 1'b1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    rx_full = 1'b0;
    end_frame();
    chk("ovf_no_write2", wq.size(), 0);
`ifdef SPI_INGRESS_STATS_EN
    chk("lost_count", lost_count, 2);
`endif

    // partial byte on early CSN rise, then clean next frame
    clear_mon();
    npart = 0;
    start_frame();
    strobe(2'b11, 0);
    strobe(2'b10, 0);
    end_frame();
    chk("partial_once", npart, 1);
    chk("partial_inactive", frame_active, 1'b0);
    start_frame();
    send_byte(8'h5A, 0);
    tick();
    chk("after_partial_count", wq.size(), 1);
    chk("after_partial_data", (wq.size() > 0) ? {24'h0, wq[0]} : 32'hDEAD, 32'h5A);
    end_frame();

    // strobes with CSN high, then reset mid-byte
    clear_mon();
    npart = 0;
    repeat (6) strobe(2'($urandom), 0);
    chk("csn_high_inactive", frame_active, 1'b0);
    chk("csn_high_no_write", wq.size(), 0);
    chk("csn_high_no_partial", npart, 0);
    start_frame();
    for (int k = 0; k < 3; k++) strobe(2'($urandom), 0);
    rst = 1'b1;
    #1;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_frame_active", frame_active, 1'b0);
    chk("midrst_rx_write", rx_write, 1'b0);
    spi_csn = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_write", wq.size(), 0);
    exp_data = 0;
    start_frame();
    send_byte(8'hC3, 2);
    tick();
    chk("c3_count", wq.size(), 1);
    chk("c3_data", (wq.size() > 0) ? {24'h0, wq[0]} : 32'hDEAD, 32'hC3);
    exp_data++;
    end_frame();

    // back-to-back strobes on every clk
    clear_mon();
    start_frame();
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    tick(); tick();
    exp_q = '{8'h01, 8'h02, 8'h03};
    cmp_queue("b2b");
    exp_data += 3;
    chk("b2b_space1", (wcyc.size() > 2) ? wcyc[1] - wcyc[0] : 32'hDEAD, 4);
    chk("b2b_space2", (wcyc.size() > 2) ? wcyc[2] - wcyc[1] : 32'hDEAD, 4);
    end_frame();

    // randomized frames against the byte-level model
    for (int f = 0; f < 8; f++) begin
      int unsigned nb, gap, tail;
      logic [7:0] b;
      clear_mon();
      exp_q.delete();
      npart = 0;
      nb   = $urandom_range(1, 5);
      tail = $urandom_range(0, 3);
      start_frame();
      for (int i = 0; i < nb; i++) begin
        b   = ($urandom_range(0, 3) == 0) ? IDLE_V : 8'($urandom);
        gap = $urandom_range(0, 2);
        send_byte(b, gap);
        if (b != IDLE_V) exp_q.push_back(b);
      end
      for (int k = 0; k < tail; k++) strobe(2'($urandom), $urandom_range(0, 1));
      tick(); tick();
      cmp_queue("rand");
      exp_data += exp_q.size();
      end_frame();
      chk("rand_partial", npart, (tail != 0) ? 1 : 0);
    end

`ifdef SPI_INGRESS_STATS_EN
    chk("data_count", data_count, exp_data);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("stats_cleared", {data_count, idle_count}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
